// File: rtl/nn_pkg.sv
// -----------------------------------------------------------------------------
// nn_pkg
// Shared definitions for the feed-forward network accelerator sequencer.
//   - seq_state_t       : sequencer FSM state encoding
//   - NN_NUM_LAYERS     : default layer count (input layer included)
//   - NN_NUM_NEURONS    : default neurons per layer
//   - NN_DATA_W         : default data word width
//   - nn_data_t         : data word typedef
//   - NN_LEARNING_RATE  : default learning-rate constant
//   - clog2_min1()      : index width helper, never returns less than 1
// No ports (package).
// -----------------------------------------------------------------------------
package nn_pkg;

    localparam int NN_NUM_LAYERS  = 4;
    localparam int NN_NUM_NEURONS = 8;
    localparam int NN_DATA_W      = 16;

    typedef logic [NN_DATA_W-1:0] nn_data_t;

    localparam nn_data_t NN_LEARNING_RATE = 16'h0080;

    typedef enum logic [3:0] {
        IDLE,
        FWD_READ,
        FWD_WRITE,
        FWD_NEXT,
        BWD_READ,
        BWD_DGEN,
        BWD_DW,
        BWD_WUPD,
        BWD_PREV,
        DONE
    } seq_state_t;

    // A single neuron or two layers still need a one-bit index.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/nn_layer_sequencer_if.sv
// -----------------------------------------------------------------------------
// nn_layer_sequencer_if
// Control bundle between the layer sequencer and the rest of the accelerator.
//   start, train, dp_ack            : controller/datapath -> sequencer
//   busy, valid                     : pass handshake
//   y_layer, w_layer, d_layer       : RAM layer indices
//   neuron_idx                      : shared neuron/column index
//   y_we, wT_we, d_rd, dw_gen,
//   d_we, w_we                      : RAM / generator strobes
//   lr                              : learning rate during delta-W generation
//   pass_count                      : completed-pass counter, present only when
//                                     NN_SEQ_PASS_CNT_EN is defined
// Modports: master = sequencer side, slave = controller/datapath side.
// -----------------------------------------------------------------------------
interface nn_layer_sequencer_if #(
    parameter int IDX_W  = 3,
    parameter int LYR_W  = 2,
    parameter int DATA_W = nn_pkg::NN_DATA_W
);

    logic              start;
    logic              train;
    logic              dp_ack;
    logic              busy;
    logic              valid;
    logic [LYR_W-1:0]  y_layer;
    logic [LYR_W-1:0]  w_layer;
    logic [LYR_W-1:0]  d_layer;
    logic [IDX_W-1:0]  neuron_idx;
    logic              y_we;
    logic              wT_we;
    logic              d_rd;
    logic              dw_gen;
    logic              d_we;
    logic              w_we;
    logic [DATA_W-1:0] lr;

`ifdef NN_SEQ_PASS_CNT_EN
    logic [31:0]       pass_count;

    modport master (
        input  start, train, dp_ack,
        output busy, valid, y_layer, w_layer, d_layer, neuron_idx,
               y_we, wT_we, d_rd, dw_gen, d_we, w_we, lr, pass_count
    );
    modport slave (
        output start, train, dp_ack,
        input  busy, valid, y_layer, w_layer, d_layer, neuron_idx,
               y_we, wT_we, d_rd, dw_gen, d_we, w_we, lr, pass_count
    );
`else
    modport master (
        input  start, train, dp_ack,
        output busy, valid, y_layer, w_layer, d_layer, neuron_idx,
               y_we, wT_we, d_rd, dw_gen, d_we, w_we, lr
    );
    modport slave (
        output start, train, dp_ack,
        input  busy, valid, y_layer, w_layer, d_layer, neuron_idx,
               y_we, wT_we, d_rd, dw_gen, d_we, w_we, lr
    );
`endif

endinterface

// File: rtl/nn_index_counter.sv
// -----------------------------------------------------------------------------
// nn_index_counter
// Two-level neuron/layer index counter used by the layer sequencer, keeping
// index arithmetic out of the FSM.
//   CLK, RST      : clock (rising edge), synchronous active-high reset
//   clr           : zero both indices
//   nrn_inc       : neuron++
//   nrn_clr       : neuron = 0 (wins over nrn_inc)
//   lyr_inc       : layer++
//   lyr_dec       : layer--
//   lyr_load_top  : layer = NUM_LAYERS-1 (start of the backward pass)
//   layer, neuron : current indices
//   layer_p1/m1   : layer+1 / layer-1 (computed one bit wider, truncated)
//   nrn_last      : neuron == NUM_NEURONS-1
//   lyr_fwd_last  : layer >= NUM_LAYERS-2 (last forward layer)
//   lyr_bwd_last  : layer <= 1 (last backward layer)
// -----------------------------------------------------------------------------
module nn_index_counter
    import nn_pkg::*;
#(
    parameter int NUM_LAYERS  = NN_NUM_LAYERS,
    parameter int NUM_NEURONS = NN_NUM_NEURONS,
    parameter int LYR_W       = clog2_min1(NUM_LAYERS),
    parameter int IDX_W       = clog2_min1(NUM_NEURONS)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             clr,
    input  logic             nrn_inc,
    input  logic             nrn_clr,
    input  logic             lyr_inc,
    input  logic             lyr_dec,
    input  logic             lyr_load_top,
    output logic [LYR_W-1:0] layer,
    output logic [LYR_W-1:0] layer_p1,
    output logic [LYR_W-1:0] layer_m1,
    output logic [IDX_W-1:0] neuron,
    output logic             nrn_last,
    output logic             lyr_fwd_last,
    output logic             lyr_bwd_last
);

    // Layer ranges never wrap, so dropping the extra bit is safe.
    assign layer_p1 = LYR_W'({1'b0, layer} + (LYR_W+1)'(1));
    assign layer_m1 = LYR_W'({1'b0, layer} - (LYR_W+1)'(1));

    assign nrn_last     = (neuron == IDX_W'(NUM_NEURONS - 1));
    assign lyr_fwd_last = (layer >= LYR_W'(NUM_LAYERS - 2));
    assign lyr_bwd_last = (layer <= LYR_W'(1));

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; RST is synchronous, hence only CLK in the event list.
    always_ff @(posedge CLK) begin
        if (RST || clr) begin
            layer  <= '0;
            neuron <= '0;
        end else begin
            if (nrn_clr)
                neuron <= '0;
            else if (nrn_inc)
                neuron <= neuron + IDX_W'(1);

            if (lyr_load_top)
                layer <= LYR_W'(NUM_LAYERS - 1);
            else if (lyr_inc)
                layer <= layer_p1;
            else if (lyr_dec)
                layer <= layer_m1;
        end
    end

endmodule

// File: rtl/nn_layer_sequencer.sv
// -----------------------------------------------------------------------------
// nn_layer_sequencer
// Walks every layer/neuron of the feed-forward network for the forward pass
// and, when train is sampled high with start, the backward pass (delta
// generation and weight update). Outputs decode the registered state and
// indices only, so nothing depends combinationally on the inputs.
//   CLK  : clock, rising edge
//   RST  : synchronous active-high reset (abandons a pass, no valid)
//   bus  : nn_layer_sequencer_if.master
//            in : start, train, dp_ack (0 stalls FWD_READ / BWD_DGEN)
//            out: busy, valid, y/w/d_layer, neuron_idx, strobes, lr
// Optional: NN_SEQ_PASS_CNT_EN adds bus.pass_count, a saturating 32-bit count
// of completed passes.
// -----------------------------------------------------------------------------
module nn_layer_sequencer
    import nn_pkg::*;
#(
    parameter int              NUM_LAYERS    = NN_NUM_LAYERS,
    parameter int              NUM_NEURONS   = NN_NUM_NEURONS,
    parameter int              IDX_W         = clog2_min1(NUM_NEURONS),
    parameter int              LYR_W         = clog2_min1(NUM_LAYERS),
    parameter int              DATA_W        = NN_DATA_W,
    parameter logic [DATA_W-1:0] LEARNING_RATE = DATA_W'(NN_LEARNING_RATE)
) (
    input  logic                  CLK,
    input  logic                  RST,
    nn_layer_sequencer_if.master  bus
);

    seq_state_t       state;
    logic             mode_train;

    logic [LYR_W-1:0] layer, layer_p1, layer_m1;
    logic [IDX_W-1:0] neuron;
    logic             nrn_last, lyr_fwd_last, lyr_bwd_last;
    logic             cnt_clr, nrn_inc, nrn_clr, lyr_inc, lyr_dec, lyr_load_top;

`ifdef NN_SEQ_PASS_CNT_EN
    logic [31:0]      pass_count;
    assign bus.pass_count = pass_count;
`endif

    // Counter commands derive from the registered state, mirroring the FSM
    // transitions below. Holding clear in IDLE gives every pass a clean start.
    assign cnt_clr      = (state == IDLE);
    assign nrn_inc      = ((state == FWD_WRITE) || (state == BWD_WUPD)) && !nrn_last;
    assign nrn_clr      = (state == FWD_NEXT) || (state == BWD_PREV);
    assign lyr_inc      = (state == FWD_NEXT) && !lyr_fwd_last;
    assign lyr_load_top = (state == FWD_NEXT) && lyr_fwd_last && mode_train;
    assign lyr_dec      = (state == BWD_PREV) && !lyr_bwd_last;

    nn_index_counter #(
        .NUM_LAYERS  (NUM_LAYERS),
        .NUM_NEURONS (NUM_NEURONS),
        .LYR_W       (LYR_W),
        .IDX_W       (IDX_W)
    ) u_index_counter (
        .CLK          (CLK),
        .RST          (RST),
        .clr          (cnt_clr),
        .nrn_inc      (nrn_inc),
        .nrn_clr      (nrn_clr),
        .lyr_inc      (lyr_inc),
        .lyr_dec      (lyr_dec),
        .lyr_load_top (lyr_load_top),
        .layer        (layer),
        .layer_p1     (layer_p1),
        .layer_m1     (layer_m1),
        .neuron       (neuron),
        .nrn_last     (nrn_last),
        .lyr_fwd_last (lyr_fwd_last),
        .lyr_bwd_last (lyr_bwd_last)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            mode_train <= 1'b0;
`ifdef NN_SEQ_PASS_CNT_EN
            pass_count <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    // start is only looked at here; DONE always returns to IDLE.
                    if (bus.start) begin
                        state      <= FWD_READ;
                        mode_train <= bus.train;
                    end
                end
                FWD_READ:  if (bus.dp_ack) state <= FWD_WRITE;
                FWD_WRITE: state <= nrn_last ? FWD_NEXT : FWD_READ;
                FWD_NEXT: begin
                    if (!lyr_fwd_last)
                        state <= FWD_READ;
                    else if (mode_train)
                        state <= BWD_READ;
                    else
                        state <= DONE;
                end
                BWD_READ:  state <= BWD_DGEN;
                BWD_DGEN:  if (bus.dp_ack) state <= BWD_DW;
                BWD_DW:    state <= BWD_WUPD;
                BWD_WUPD:  state <= nrn_last ? BWD_PREV : BWD_READ;
                BWD_PREV:  state <= lyr_bwd_last ? DONE : BWD_READ;
                DONE: begin
                    state <= IDLE;
`ifdef NN_SEQ_PASS_CNT_EN
                    if (pass_count != '1)
                        pass_count <= pass_count + 32'd1;
`endif
                end
                default:   state <= IDLE;
            endcase
        end
    end

    always_comb begin
        // NOTE: every output is given a default before the case so that no
        // state leaves a value unassigned and infers a latch.
        bus.busy       = (state != IDLE);
        bus.valid      = 1'b0;
        bus.y_layer    = '0;
        bus.w_layer    = '0;
        bus.d_layer    = '0;
        bus.neuron_idx = '0;
        bus.y_we       = 1'b0;
        bus.wT_we      = 1'b0;
        bus.d_rd       = 1'b0;
        bus.dw_gen     = 1'b0;
        bus.d_we       = 1'b0;
        bus.w_we       = 1'b0;
        bus.lr         = '0;
        case (state)
            FWD_READ: begin
                bus.y_layer    = layer;
                bus.w_layer    = layer;
                bus.neuron_idx = neuron;
            end
            FWD_WRITE: begin
                bus.y_we       = 1'b1;
                bus.wT_we      = 1'b1;
                bus.y_layer    = layer_p1;
                bus.w_layer    = layer;
                bus.neuron_idx = neuron;
            end
            BWD_READ: begin
                bus.d_layer    = layer;
                bus.w_layer    = layer_m1;
                bus.y_layer    = layer_m1;
                bus.neuron_idx = neuron;
            end
            BWD_DGEN: begin
                bus.d_rd       = 1'b1;
                bus.neuron_idx = neuron;
            end
            BWD_DW: begin
                bus.dw_gen     = 1'b1;
                bus.d_we       = 1'b1;
                bus.lr         = LEARNING_RATE;
                bus.neuron_idx = neuron;
            end
            BWD_WUPD: begin
                bus.w_we       = 1'b1;
                bus.w_layer    = layer_m1;
                bus.neuron_idx = neuron;
            end
            DONE:    bus.valid = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_nn_layer_sequencer.sv
// -----------------------------------------------------------------------------
// tb_nn_layer_sequencer
// Directed self-checking bench for nn_layer_sequencer with L=3, N=2.
// Inputs change and outputs are sampled on the falling clock edge.
// Scenarios: reset, forward-only pass, training pass, dp_ack stall, reset
// during BWD_DW, start held high, and (with NN_SEQ_PASS_CNT_EN) pass_count.
// -----------------------------------------------------------------------------
module tb_nn_layer_sequencer;

    localparam int L      = 3;
    localparam int N      = 2;
    localparam int LYR_W  = 2;
    localparam int IDX_W  = 1;
    localparam int DATA_W = 16;
    localparam logic [DATA_W-1:0] LR = 16'h0080;

    typedef logic [LYR_W+IDX_W-1:0] ev_t;   // {layer, neuron}

    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   vectors     = 0;
    int   miscompares = 0;

    ev_t  y_ev[$], wt_ev[$], w_ev[$], d_ev[$];
    int   n_drd, n_dw, n_badlr, n_badwt, n_baddwe, n_badbr, n_notbusy;

    nn_layer_sequencer_if #(.IDX_W(IDX_W), .LYR_W(LYR_W), .DATA_W(DATA_W)) bus ();

    nn_layer_sequencer #(
        .NUM_LAYERS    (L),
        .NUM_NEURONS   (N),
        .IDX_W         (IDX_W),
        .LYR_W         (LYR_W),
        .DATA_W        (DATA_W),
        .LEARNING_RATE (LR)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.master)
    );

    always #5 CLK = ~CLK;

    task automatic clear_logs();
        y_ev.delete(); wt_ev.delete(); w_ev.delete(); d_ev.delete();
        n_drd = 0; n_dw = 0; n_badlr = 0; n_badwt = 0;
        n_baddwe = 0; n_badbr = 0; n_notbusy = 0;
    endtask

    // Record strobe activity for the current (negedge) cycle.
    task automatic log_cycle();
        if (bus.y_we)  y_ev.push_back({bus.y_layer, bus.neuron_idx});
        if (bus.wT_we) wt_ev.push_back({bus.w_layer, bus.neuron_idx});
        if (bus.w_we)  w_ev.push_back({bus.w_layer, bus.neuron_idx});
        if (bus.d_layer != '0) begin
            d_ev.push_back({bus.d_layer, bus.neuron_idx});
            if (bus.y_layer !== LYR_W'(bus.d_layer - 2'd1) ||
                bus.w_layer !== LYR_W'(bus.d_layer - 2'd1)) n_badbr++;
        end
        if (bus.d_rd) n_drd++;
        if (bus.dw_gen) begin
            n_dw++;
            if (bus.lr !== LR) n_badlr++;
        end else if (bus.lr !== '0) n_badlr++;
        if (bus.wT_we !== bus.y_we)   n_badwt++;
        if (bus.d_we  !== bus.dw_gen) n_baddwe++;
        if (bus.busy  !== 1'b1)       n_notbusy++;
    endtask

    // Called at a negedge; leaves the bench at the negedge after the accept edge.
    task automatic start_pass(input logic tr);
        bus.start = 1'b1;
        bus.train = tr;
        @(posedge CLK);
        @(negedge CLK);
        bus.start = 1'b0;
        bus.train = 1'b0;
    endtask

    // Counts rising edges until valid is seen; -1 if the budget runs out.
    task automatic wait_valid(output int edges);
        edges = -1;
        log_cycle();
        for (int i = 1; i <= 200; i++) begin
            @(posedge CLK);
            @(negedge CLK);
            log_cycle();
            if (bus.valid) begin
                edges = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        logic [5:0] strobes;
        repeat (2) @(negedge CLK);
        strobes = {bus.y_we, bus.wT_we, bus.d_rd, bus.dw_gen, bus.d_we, bus.w_we};
        vectors++;
        if ({bus.busy, bus.valid} !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_busy_valid: got %b expected 00", {bus.busy, bus.valid});
        end
        vectors++;
        if ({bus.y_layer, bus.w_layer, bus.d_layer, bus.neuron_idx} !== '0) begin
            miscompares++;
            $display("FAIL reset_indices: got %h expected 0",
                     {bus.y_layer, bus.w_layer, bus.d_layer, bus.neuron_idx});
        end
        vectors++;
        if (strobes !== 6'b0) begin
            miscompares++;
            $display("FAIL reset_strobes: got %b expected 000000", strobes);
        end
        vectors++;
        if (bus.lr !== '0) begin
            miscompares++;
            $display("FAIL reset_lr: got %h expected 0000", bus.lr);
        end
        // start coincident with RST: RST wins.
        bus.start = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        bus.start = 1'b0;
        RST = 1'b0;
        vectors++;
        if (bus.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL start_with_rst: busy got %b expected 0", bus.busy);
        end
        @(posedge CLK);
        @(negedge CLK);
        vectors++;
        if (bus.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_after_rst: busy got %b expected 0", bus.busy);
        end
    endtask

    task automatic test_forward();
        int  edges;
        ev_t exp_y [4];
        ev_t exp_wt[4];
        exp_y  = '{3'b010, 3'b011, 3'b100, 3'b101};  // (1,0)(1,1)(2,0)(2,1)
        exp_wt = '{3'b000, 3'b001, 3'b010, 3'b011};  // (0,0)(0,1)(1,0)(1,1)
        clear_logs();
        start_pass(1'b0);
        vectors++;
        if ({bus.busy, bus.y_layer, bus.w_layer, bus.y_we} !== 6'b1_00_00_0) begin
            miscompares++;
            $display("FAIL fwd_first_read: got %b expected 100000",
                     {bus.busy, bus.y_layer, bus.w_layer, bus.y_we});
        end
        wait_valid(edges);
        vectors++;
        if (edges !== 10) begin
            miscompares++;
            $display("FAIL fwd_length: got %0d edges expected 10", edges);
        end
        vectors++;
        if (y_ev.size() !== 4 || wt_ev.size() !== 4) begin
            miscompares++;
            $display("FAIL fwd_write_count: got y %0d wT %0d expected 4 4",
                     y_ev.size(), wt_ev.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                vectors++;
                if (y_ev[i] !== exp_y[i] || wt_ev[i] !== exp_wt[i]) begin
                    miscompares++;
                    $display("FAIL fwd_write_%0d: got y %b wT %b expected y %b wT %b",
                             i, y_ev[i], wt_ev[i], exp_y[i], exp_wt[i]);
                end
            end
        end
        vectors++;
        if ({w_ev.size(), n_drd, n_dw, n_badwt, n_badlr, n_notbusy} !== '0) begin
            miscompares++;
            $display("FAIL fwd_no_bwd: got w_we %0d d_rd %0d dw %0d badwt %0d badlr %0d notbusy %0d expected all 0",
                     w_ev.size(), n_drd, n_dw, n_badwt, n_badlr, n_notbusy);
        end
        @(posedge CLK);
        @(negedge CLK);
        vectors++;
        if ({bus.busy, bus.valid} !== 2'b00) begin
            miscompares++;
            $display("FAIL fwd_after_done: got %b expected 00", {bus.busy, bus.valid});
        end
    endtask

    task automatic test_train();
        int  edges;
        ev_t exp_w[4];
        ev_t exp_d[4];
        exp_w = '{3'b010, 3'b011, 3'b000, 3'b001};   // (1,0)(1,1)(0,0)(0,1)
        exp_d = '{3'b100, 3'b101, 3'b010, 3'b011};   // (2,0)(2,1)(1,0)(1,1)
        clear_logs();
        start_pass(1'b1);
        wait_valid(edges);
        vectors++;
        if (edges !== 28) begin
            miscompares++;
            $display("FAIL train_length: got %0d edges expected 28", edges);
        end
        vectors++;
        if (w_ev.size() !== 4 || d_ev.size() !== 4) begin
            miscompares++;
            $display("FAIL train_bwd_count: got w_we %0d d_read %0d expected 4 4",
                     w_ev.size(), d_ev.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                vectors++;
                if (w_ev[i] !== exp_w[i] || d_ev[i] !== exp_d[i]) begin
                    miscompares++;
                    $display("FAIL train_bwd_%0d: got w %b d %b expected w %b d %b",
                             i, w_ev[i], d_ev[i], exp_w[i], exp_d[i]);
                end
            end
        end
        vectors++;
        if (n_drd !== 4 || n_dw !== 4 || y_ev.size() !== 4) begin
            miscompares++;
            $display("FAIL train_strobe_count: got d_rd %0d dw_gen %0d y_we %0d expected 4 4 4",
                     n_drd, n_dw, y_ev.size());
        end
        vectors++;
        if ({n_badlr, n_baddwe, n_badbr, n_notbusy} !== '0) begin
            miscompares++;
            $display("FAIL train_decode: got badlr %0d baddwe %0d badbr %0d notbusy %0d expected all 0",
                     n_badlr, n_baddwe, n_badbr, n_notbusy);
        end
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic test_stall();
        int edges;
        clear_logs();
        bus.dp_ack = 1'b0;
        start_pass(1'b0);
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if ({bus.busy, bus.y_layer, bus.w_layer, bus.neuron_idx, bus.y_we} !== 7'b1_00_00_0_0) begin
                miscompares++;
                $display("FAIL stall_hold_%0d: got %b expected 1000000", i,
                         {bus.busy, bus.y_layer, bus.w_layer, bus.neuron_idx, bus.y_we});
            end
            @(posedge CLK);
            @(negedge CLK);
        end
        bus.dp_ack = 1'b1;
        wait_valid(edges);
        vectors++;
        if (edges < 0 || edges + 3 !== 13) begin
            miscompares++;
            $display("FAIL stall_length: got %0d edges expected 13",
                     (edges < 0) ? edges : edges + 3);
        end
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic test_mid_reset();
        int         edges;
        int         bad;
        logic [5:0] strobes;
        start_pass(1'b1);
        for (int i = 0; i < 100; i++) begin
            if (bus.dw_gen) break;
            @(posedge CLK);
            @(negedge CLK);
        end
        vectors++;
        if (bus.dw_gen !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_reset_reach_dw: dw_gen got %b expected 1", bus.dw_gen);
        end
        RST = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        strobes = {bus.y_we, bus.wT_we, bus.d_rd, bus.dw_gen, bus.d_we, bus.w_we};
        vectors++;
        if ({bus.busy, bus.valid, strobes, bus.lr} !== '0 ||
            {bus.y_layer, bus.w_layer, bus.d_layer, bus.neuron_idx} !== '0) begin
            miscompares++;
            $display("FAIL mid_reset_outputs: got busy %b valid %b strobes %b lr %h idx %h expected all 0",
                     bus.busy, bus.valid, strobes, bus.lr,
                     {bus.y_layer, bus.w_layer, bus.d_layer, bus.neuron_idx});
        end
        bad = 0;
        repeat (4) begin
            @(posedge CLK);
            @(negedge CLK);
            if (bus.valid !== 1'b0 || bus.busy !== 1'b0) bad++;
        end
        vectors++;
        if (bad !== 0) begin
            miscompares++;
            $display("FAIL mid_reset_abandon: got %0d active cycles expected 0", bad);
        end
        start_pass(1'b0);
        wait_valid(edges);
        vectors++;
        if (edges !== 10) begin
            miscompares++;
            $display("FAIL mid_reset_new_pass: got %0d edges expected 10", edges);
        end
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic test_start_held();
        int edges;
        bus.start = 1'b1;
        bus.train = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        wait_valid(edges);
        vectors++;
        if (edges !== 10) begin
            miscompares++;
            $display("FAIL held_first_pass: got %0d edges expected 10", edges);
        end
        @(posedge CLK);
        @(negedge CLK);
        vectors++;
        if (bus.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL held_done_ignores_start: busy got %b expected 0", bus.busy);
        end
        @(posedge CLK);
        @(negedge CLK);
        vectors++;
        if (bus.busy !== 1'b1) begin
            miscompares++;
            $display("FAIL held_second_pass: busy got %b expected 1", bus.busy);
        end
        bus.start = 1'b0;
        wait_valid(edges);
        vectors++;
        if (edges !== 10) begin
            miscompares++;
            $display("FAIL held_second_length: got %0d edges expected 10", edges);
        end
        // start present only during DONE: must not launch a pass.
        bus.start = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        bus.start = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        vectors++;
        if (bus.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL start_in_done: busy got %b expected 0", bus.busy);
        end
    endtask

`ifdef NN_SEQ_PASS_CNT_EN
    task automatic test_pass_count();
        int edges;
        RST = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        vectors++;
        if (bus.pass_count !== 32'd0) begin
            miscompares++;
            $display("FAIL pass_count_reset: got %0d expected 0", bus.pass_count);
        end
        for (int k = 1; k <= 3; k++) begin
            start_pass(1'b0);
            wait_valid(edges);
            @(posedge CLK);
            @(negedge CLK);
            vectors++;
            if (bus.pass_count !== 32'(k)) begin
                miscompares++;
                $display("FAIL pass_count_%0d: got %0d expected %0d", k, bus.pass_count, k);
            end
        end
        RST = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        vectors++;
        if (bus.pass_count !== 32'd0) begin
            miscompares++;
            $display("FAIL pass_count_clear: got %0d expected 0", bus.pass_count);
        end
    endtask
`endif

    initial begin
        bus.start  = 1'b0;
        bus.train  = 1'b0;
        bus.dp_ack = 1'b1;
        RST        = 1'b1;
        test_reset();
        test_forward();
        test_train();
        test_stall();
        test_mid_reset();
        test_start_held();
`ifdef NN_SEQ_PASS_CNT_EN
        test_pass_count();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
